// File: rtl/citadel_key_presenter_if.sv
// Presenter-side bus: serial key ingress, comparator key/result pair, and status outputs.
interface citadel_key_presenter_if #(
    parameter int KEY_W = 8
);
    logic             ser_start;
    logic             ser_valid;
    logic             ser_data;
    logic [KEY_W-1:0] key_input;
    logic             is_authorized;
    logic             auth_ok;
    logic             auth_fail;
    logic             locked;
    logic             busy;
    logic [3:0]       fail_count;

    modport master (
        input  ser_start, ser_valid, ser_data, is_authorized,
        output key_input, auth_ok, auth_fail, locked, busy, fail_count
    );

    modport slave (
        output ser_start, ser_valid, ser_data, is_authorized,
        input  key_input, auth_ok, auth_fail, locked, busy, fail_count
    );
endinterface

// File: rtl/citadel_key_presenter.sv
// Assembles a serial candidate key, presents it to the comparator for one cycle,
// reports the verdict and enforces a failed-attempt lockout.
module citadel_key_presenter #(
    parameter int KEY_W          = 8,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 1024,
    parameter int BIT_TIMEOUT    = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    citadel_key_presenter_if.master bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHIFT   = 3'd1;
    localparam logic [2:0] S_PRESENT = 3'd2;
    localparam logic [2:0] S_RESULT  = 3'd3;
    localparam logic [2:0] S_LOCKOUT = 3'd4;

    localparam int BC_W = (KEY_W > 2) ? $clog2(KEY_W) : 1;
    localparam int TO_W = $clog2(BIT_TIMEOUT + 1);
    localparam int LC_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(KEY_W - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(BIT_TIMEOUT - 1);
    localparam logic [LC_W-1:0] LC_LAST  = LC_W'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]      FAIL_MAX = 4'(MAX_FAIL);

    logic [2:0]       state;
    logic [KEY_W-1:0] sr;
    logic [KEY_W-1:0] sr_nxt;
    logic [BC_W-1:0]  bit_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [LC_W-1:0]  lock_cnt;
    logic [KEY_W-1:0] key_q;
    logic             ok_q;
    logic             fail_q;
    logic             locked_q;
    logic [3:0]       fail_cnt;
    logic [3:0]       fail_inc;

    assign sr_nxt   = {sr[KEY_W-2:0], bus.ser_data};
    // Saturating increment; the lockout path clears the count before it could wrap.
    assign fail_inc = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sr       <= '0;
            bit_cnt  <= '0;
            to_cnt   <= '0;
            lock_cnt <= '0;
            key_q    <= '0;
            ok_q     <= 1'b0;
            fail_q   <= 1'b0;
            locked_q <= 1'b0;
            fail_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.ser_start) begin
                        state   <= S_SHIFT;
                        sr      <= '0;
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (bus.ser_start) begin
                        sr      <= '0;
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                    end else if (bus.ser_valid) begin
                        sr      <= sr_nxt;
                        bit_cnt <= bit_cnt + 1'b1;
                        to_cnt  <= '0;
                        // Key register loads with the final bit so it is live exactly in PRESENT.
                        if (bit_cnt == BC_LAST) begin
                            state <= S_PRESENT;
                            key_q <= sr_nxt;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (to_cnt == TO_LAST) begin
                            state  <= S_RESULT;
                            fail_q <= 1'b1;
                        end
                    end
                end
                S_PRESENT: begin
                    key_q  <= '0;
                    sr     <= '0;
                    ok_q   <= bus.is_authorized;
                    fail_q <= ~bus.is_authorized;
                    state  <= S_RESULT;
                end
                S_RESULT: begin
                    ok_q   <= 1'b0;
                    fail_q <= 1'b0;
                    if (ok_q) begin
                        fail_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        fail_cnt <= fail_inc;
                        if (fail_inc == FAIL_MAX) begin
                            state    <= S_LOCKOUT;
                            locked_q <= 1'b1;
                            lock_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (lock_cnt == LC_LAST) begin
                        state    <= S_IDLE;
                        locked_q <= 1'b0;
                        fail_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.key_input  = key_q;
    assign bus.auth_ok    = ok_q;
    assign bus.auth_fail  = fail_q;
    assign bus.locked     = locked_q;
    assign bus.busy       = (state != S_IDLE);
    assign bus.fail_count = fail_cnt;
endmodule

// File: tb/tb_citadel_key_presenter.sv
// Directed bench for citadel_key_presenter with a comparator model and a verdict scoreboard.
module tb_citadel_key_presenter;
    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] ref_key;

    citadel_key_presenter_if #(.KEY_W(8)) bus ();

    citadel_key_presenter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Comparator model: combinational match against the reference key.
    assign bus.is_authorized = (bus.key_input == ref_key);

    typedef struct {
        bit         ok;
        logic [7:0] key;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] seen_key = '0;
    int   nz_cycles = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Verdict monitor: key bus activity is recorded, each pulse pops one expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.key_input != 8'h00) begin
                seen_key = bus.key_input;
                nz_cycles++;
            end
            if (bus.auth_ok || bus.auth_fail) begin
                if (sb.size() == 0) begin
                    chk("spurious_pulse", {30'd0, bus.auth_ok, bus.auth_fail}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_auth_ok", bus.auth_ok, e.ok);
                    chk("sb_auth_fail", bus.auth_fail, !e.ok);
                    chk("sb_key_seen", seen_key, e.key);
                    chk("sb_key_cycles", nz_cycles, (e.key != 8'h00) ? 1 : 0);
                end
                seen_key  = '0;
                nz_cycles = 0;
            end
        end
    end

    task automatic send_frame(input logic [7:0] key, input bit exp_ok, input logic [3:0] exp_fc);
        sb.push_back('{exp_ok, key});
        bus.ser_start = 1'b1;
        tick();
        bus.ser_start = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            bus.ser_valid = 1'b1;
            bus.ser_data  = key[i];
            tick();
        end
        bus.ser_valid = 1'b0;
        bus.ser_data  = 1'b0;
        chk("present_key", bus.key_input, key);
        tick();
        chk("result_auth_ok", bus.auth_ok, exp_ok);
        chk("result_auth_fail", bus.auth_fail, !exp_ok);
        chk("result_key_zero", bus.key_input, 8'h00);
        tick();
        chk("fail_count", bus.fail_count, exp_fc);
        chk("pulse_cleared", {bus.auth_ok, bus.auth_fail}, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lock_len;
        logic [7:0] bk;
        bk            = 8'hB6;
        ref_key       = 8'hB6;
        rst_n         = 1'b0;
        bus.ser_start = 1'b0;
        bus.ser_valid = 1'b0;
        bus.ser_data  = 1'b0;
        #1;
        chk("rst_key_input", bus.key_input, 8'h00);
        chk("rst_auth_ok", bus.auth_ok, 1'b0);
        chk("rst_auth_fail", bus.auth_fail, 1'b0);
        chk("rst_locked", bus.locked, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_fail_count", bus.fail_count, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Correct key passes
        send_frame(8'hB6, 1'b1, 4'd0);
        chk("idle_after_pass", bus.busy, 1'b0);

        // Three wrong keys lock out; inputs during lockout are ignored
        send_frame(8'h00, 1'b0, 4'd1);
        send_frame(8'h00, 1'b0, 4'd2);
        send_frame(8'h00, 1'b0, 4'd3);
        chk("lock_entered", bus.locked, 1'b1);
        lock_len = 1;
        for (int c = 0; c < 2000; c++) begin
            if (c == 0) begin
                bus.ser_start = 1'b1;
            end else if (c <= 8) begin
                bus.ser_start = 1'b0;
                bus.ser_valid = 1'b1;
                bus.ser_data  = bk[8-c];
            end else begin
                bus.ser_valid = 1'b0;
                bus.ser_data  = 1'b0;
            end
            tick();
            if (!bus.locked) break;
            lock_len++;
        end
        chk("lock_length", lock_len, 1024);
        chk("lock_fail_count_clr", bus.fail_count, 4'd0);
        chk("lock_exit_idle", bus.busy, 1'b0);
        chk("lock_no_key", bus.key_input, 8'h00);

        // Pass clears the count; a later failure does not lock
        send_frame(8'h00, 1'b0, 4'd1);
        send_frame(8'h5A, 1'b0, 4'd2);
        send_frame(8'hB6, 1'b1, 4'd0);
        send_frame(8'h01, 1'b0, 4'd1);
        chk("single_fail_no_lock", bus.locked, 1'b0);
        send_frame(8'hB6, 1'b1, 4'd0);

        // Inter-bit timeout aborts as a failure
        sb.push_back('{1'b0, 8'h00});
        bus.ser_start = 1'b1;
        tick();
        bus.ser_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.ser_valid = 1'b1;
            bus.ser_data  = 1'b1;
            tick();
        end
        bus.ser_valid = 1'b0;
        bus.ser_data  = 1'b0;
        for (int i = 0; i < 254; i++) tick();
        chk("timeout_not_yet", bus.auth_fail, 1'b0);
        chk("timeout_busy", bus.busy, 1'b1);
        tick();
        chk("timeout_auth_fail", bus.auth_fail, 1'b1);
        chk("timeout_key_zero", bus.key_input, 8'h00);
        tick();
        chk("timeout_fail_count", bus.fail_count, 4'd1);
        chk("timeout_idle", bus.busy, 1'b0);

        // Restart mid-frame discards the partial frame
        bus.ser_start = 1'b1;
        tick();
        bus.ser_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.ser_valid = 1'b1;
            bus.ser_data  = 1'b1;
            tick();
        end
        bus.ser_valid = 1'b0;
        send_frame(8'hB6, 1'b1, 4'd0);

        // Reset during lockout clears it immediately
        send_frame(8'h00, 1'b0, 4'd1);
        send_frame(8'h00, 1'b0, 4'd2);
        send_frame(8'h00, 1'b0, 4'd3);
        chk("lock2_entered", bus.locked, 1'b1);
        for (int i = 0; i < 100; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_locked", bus.locked, 1'b0);
        chk("rst_mid_fail_count", bus.fail_count, 4'd0);
        chk("rst_mid_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", bus.busy, 1'b0);
        send_frame(8'hB6, 1'b1, 4'd0);

        tick();
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
